// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int PC_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Word-address increment; wraps 32'hFFFF_FFFF to 0.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// Handshake: imem_req is held with a stable imem_addr until a cycle with imem_ack=1;
// the transfer completes on the rising edge of that cycle, and imem_rdata is valid only then.
interface pc_fetch_if;

    logic                       imem_req;
    logic [fetch_pkg::PC_W-1:0] imem_addr;
    logic                       imem_ack;
    logic [31:0]                imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pc_fetch.sv
// Fetch stage: program counter, imem request and the IF/ID pipeline register.
// Redirect beats stall beats normal flow; a redirect with a request in flight drains it first.
module pc_fetch
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    pc_fetch_if.master        imem,
    output logic              if_valid,
    output logic [PC_W-1:0]   if_pc,
    output logic [31:0]       if_instr,
    output fetch_state_t      fsm_state
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_q, pend_d;
    logic [31:0]     buf_q, buf_d;
    logic            if_valid_d;
    logic [PC_W-1:0] if_pc_d;
    logic [31:0]     if_instr_d;

    assign imem.imem_req  = (state_q != HOLD);
    assign imem.imem_addr = pc_q;
    assign fsm_state      = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            pend_q   <= '0;
            buf_q    <= NOP_INSTR;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= NOP_INSTR;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            buf_q    <= buf_d;
            if_valid <= if_valid_d;
            if_pc    <= if_pc_d;
            if_instr <= if_instr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        buf_d      = buf_q;
        if_valid_d = if_valid;
        if_pc_d    = if_pc;
        if_instr_d = if_instr;

        if (redirect) begin
            if_valid_d = 1'b0;
            if (state_q == HOLD || (state_q == FETCH && imem.imem_ack)) begin
                pc_d    = redirect_pc;
                state_d = FETCH;
            end else begin
                // Request still in flight: remember the target, keep the request untouched.
                pend_d  = redirect_pc;
                state_d = DRAIN;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (stall) begin
                        if (imem.imem_ack) begin
                            buf_d   = imem.imem_rdata;
                            state_d = HOLD;
                        end
                    end else if (imem.imem_ack) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = imem.imem_rdata;
                        pc_d       = pc_inc(pc_q);
                    end else begin
                        if_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = buf_q;
                        pc_d       = pc_inc(pc_q);
                        state_d    = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem.imem_ack) begin
                        pc_d    = pend_q;
                        state_d = FETCH;
                        if (!stall) begin
                            if_valid_d = 1'b0;
                        end
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch stage. It holds the program counter, drives the instruction-memory request, and loads the IF/ID pipeline register. It consumes the branch/jump unit's target (`redirect_pc`) and taken flag (`redirect`). PCs are word addresses: sequential next PC is pc+1. Its `if_pc` output feeds the branch/jump unit's PC input in ID.

## Interface
- `RESET_PC`, default 32'h0000_0000, first word address fetched after reset.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall` input 1: hazard-unit stall. IF/ID and PC hold.
- `redirect` input 1: branch/jump taken (pc_bj), flushes IF/ID.
- `redirect_pc` input 32: target word address.
- `imem_req` output 1: fetch request. Held with stable `imem_addr` until `imem_ack`.
- `imem_addr` output 32: word address requested.
- `imem_ack` input 1: response valid this cycle. May come in the same cycle as `imem_req` or later.
- `imem_rdata` input 32: instruction, valid when `imem_ack`=1.
- `if_valid` output 1: IF/ID holds a real instruction.
- `if_pc` output 32: word address of `if_instr`.
- `if_instr` output 32: fetched instruction.

## Operation
- State machine:
  - FETCH: request outstanding at `pc`.
  - HOLD: instruction buffered while stalled, no request.
  - DRAIN: stale request outstanding, its response is discarded.
- Request outputs:
  - `imem_req`=1 in FETCH and DRAIN, 0 in HOLD.
  - `imem_addr`=`pc` in FETCH and DRAIN. It never changes while `imem_req`=1 and `imem_ack`=0.
- Evaluation priority per cycle: `redirect` > `stall` > normal.
- `redirect`=1:
  - `if_valid`<=0, regardless of `stall`.
  - FETCH with `ack`=1, or HOLD: `pc`<=`redirect_pc`, go to FETCH. Any response or buffer is dropped.
  - FETCH with `ack`=0: `pend`<=`redirect_pc`, go to DRAIN.
  - DRAIN: `pend`<=`redirect_pc` (latest target wins). The outstanding request is unchanged.
- DRAIN, `ack`=1, no redirect: response dropped, `pc`<=`pend`, go to FETCH. `if_valid` keeps its value under `stall`, else becomes 0.
- FETCH, `stall`=0:
  - `ack`=1: IF/ID<={1, `pc`, `imem_rdata`}, `pc`<=`pc`+1.
  - `ack`=0: `if_valid`<=0 (bubble).
- FETCH, `stall`=1:
  - IF/ID holds.
  - `ack`=1: `buf`<=`imem_rdata`, go to HOLD (`pc` unchanged).
- HOLD:
  - `stall`=1: hold everything.
  - `stall`=0: IF/ID<={1, `pc`, `buf`}, `pc`<=`pc`+1, go to FETCH.
- Arithmetic: `pc`+1 is 32-bit and wraps 32'hFFFF_FFFF to 0. No alignment checks.

## Timing
- Reset values:
  - state=FETCH, `pc`=`RESET_PC`, `pend`=0, `buf`=0.
  - `if_valid`=0, `if_pc`=0, `if_instr`=32'h0000_0000 (NOP).
  - `imem_req`=1 and `imem_addr`=`RESET_PC` combinationally while in reset and after deassertion.
- Reset mid-DRAIN or mid-HOLD: everything returns to reset values immediately. The stale response is the memory's responsibility.
- Latency:
  - The instruction acked at edge k appears on `if_*` after edge k.
  - With a same-cycle-ack memory: one instruction per cycle, and a redirect at edge k yields `if_valid` for the target after edge k+1 (one bubble).
- Stall release from HOLD: the buffered instruction is presented at the next edge with no memory access. The refetch of `pc`+1 starts the cycle after.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum {FETCH, HOLD, DRAIN}.
  - `NOP_INSTR`=32'h0.
  - `PC_W`=32.
- One module. The IF/ID register may be split into sub-module `if_id_reg` (enable=!`stall`, sync flush=`redirect`, async reset). This is optional; no other sub-modules.

## Test plan
- Reset, `RESET_PC`=32'h10, `ack` always 1: `if_pc` sequence 10, 11, 12, … one per cycle, `if_valid`=1 from the first edge after reset release.
- `ack` delayed 3 cycles per request: `imem_addr` stable during each wait, `if_valid`=0 bubbles in between, PCs consecutive.
- Redirect to 32'h40 while `pc`=32'h13 awaits `ack`: DRAIN, data at 13 never appears on `if_*`, next `if_pc`=40. A second redirect to 32'h80 during DRAIN gives next `if_pc`=80.
- `stall`=1 for 4 cycles while `ack` arrives for `pc`=32'h20: IF/ID frozen, HOLD with `imem_req`=0, and on release `if_pc`=20 with the buffered instruction, then 21.
- `redirect` and `stall` together in HOLD: `if_valid`=0, buffer dropped, fetch resumes at `redirect_pc`.
- `pc`=32'hFFFF_FFFF fetched: next `if_pc`=0. Asserting `rst_n`=0 in DRAIN immediately restores all reset values.
